// File: rtl/anb_wr_burst_chopper_if.sv
// ANB write address/data channel interfaces used by anb_wr_burst_chopper.
// Modport m drives a channel, modport s receives it.
interface anb_addr_channel_if #(
    parameter type ADDR_T = logic [31:0],
    parameter type LEN_T  = logic [7:0]
);
    logic  avalid;
    logic  aready;
    ADDR_T addr;
    LEN_T  len;

    modport m (output avalid, output addr, output len, input aready);
    modport s (input avalid, input addr, input len, output aready);
endinterface

interface anb_data_channel_if #(
    parameter type DATA_T = logic [63:0]
);
    logic  valid;
    logic  ready;
    DATA_T data;
    logic  last;

    modport m (output valid, output data, output last, input ready);
    modport s (input valid, input data, input last, output ready);
endinterface

// File: rtl/anb_wr_burst_chopper.sv
// ANB write burst chopper: re-issues one write command as sub-bursts of at most MAX_BEATS
// beats and regenerates data last per sub-burst. Define ANB_WR_CHOPPER_BOUNDARY_EN to also
// keep every sub-burst inside one BOUNDARY_BYTES window.
module anb_wr_burst_chopper #(
    parameter type ADDR_T         = logic [31:0],
    parameter type LEN_T          = logic [7:0],
    parameter type DATA_T         = logic [63:0],
    parameter int  BEAT_BYTES     = 8,
    parameter int  MAX_BEATS      = 16,
    parameter int  CMD_DEPTH      = 4,
    parameter int  BOUNDARY_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    anb_addr_channel_if.s m_a,
    anb_addr_channel_if.m s_a,
    anb_data_channel_if.s m_d,
    anb_data_channel_if.m s_d,
    output logic          err_last
);
    localparam int LEN_W      = $bits(LEN_T);
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int PTR_W      = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W      = $clog2(CMD_DEPTH + 1);

    typedef logic [LEN_W:0]   rem_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    if (((BEAT_BYTES & (BEAT_BYTES - 1)) != 0) || ((MAX_BEATS & (MAX_BEATS - 1)) != 0) ||
        (MAX_BEATS > (1 << LEN_W)) || ($bits(DATA_T) != 8 * BEAT_BYTES) ||
        ((BOUNDARY_BYTES & (BOUNDARY_BYTES - 1)) != 0) || (BOUNDARY_BYTES < BEAT_BYTES))
    begin : g_bad_params
        $error("anb_wr_burst_chopper: inconsistent parameters");
    end

    state_t           state_q, state_d;
    ADDR_T            cur_addr_q, cur_addr_d;
    rem_t             rem_q, rem_d;
    LEN_T             orig_len_q, orig_len_d;
    logic             first_q, first_d;
    LEN_T             sub_mem_q [CMD_DEPTH];
    LEN_T             sub_mem_d [CMD_DEPTH];
    LEN_T             orig_mem_q [CMD_DEPTH];
    LEN_T             orig_mem_d [CMD_DEPTH];
    ptr_t             sub_wr_q, sub_wr_d, sub_rd_q, sub_rd_d;
    ptr_t             orig_wr_q, orig_wr_d, orig_rd_q, orig_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    LEN_T             beat_cnt_q, beat_cnt_d;
    LEN_T             orig_cnt_q, orig_cnt_d;
    logic             err_q, err_d;

    rem_t             chunk;
    LEN_T             chunk_len;
    logic             fifo_full, fifo_nonempty;
    logic             a_hs, sa_hs, d_hs;
    logic             sub_last, orig_end;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(CMD_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

`ifdef ANB_WR_CHOPPER_BOUNDARY_EN
    localparam int BND_SHIFT = $clog2(BOUNDARY_BYTES);
    logic [BND_SHIFT:0] bnd_beats;
`endif

    always_comb begin
        chunk = (rem_q > rem_t'(MAX_BEATS)) ? rem_t'(MAX_BEATS) : rem_q;
`ifdef ANB_WR_CHOPPER_BOUNDARY_EN
        // Beats left before the next boundary; a full window when cur_addr sits on one.
        bnd_beats = ((BND_SHIFT + 1)'(BOUNDARY_BYTES) - {1'b0, cur_addr_q[BND_SHIFT-1:0]})
                    >> BEAT_SHIFT;
        if (int'(bnd_beats) < int'(chunk)) begin
            chunk = rem_t'(bnd_beats);
        end
`endif
        chunk_len = LEN_T'(chunk - rem_t'(1));
    end

    assign fifo_full     = (cnt_q == CNT_W'(CMD_DEPTH));
    assign fifo_nonempty = (cnt_q != '0);

    assign m_a.aready = rst && (state_q == ST_IDLE);
    assign s_a.avalid = (state_q == ST_ISSUE) && !fifo_full;
    assign s_a.addr   = cur_addr_q;
    assign s_a.len    = chunk_len;
    assign a_hs       = m_a.avalid && m_a.aready;
    assign sa_hs      = s_a.avalid && s_a.aready;

    // Data path is purely combinational; beats only flow while a sub-burst length is queued.
    assign s_d.valid = m_d.valid && fifo_nonempty;
    assign m_d.ready = s_d.ready && fifo_nonempty;
    assign s_d.data  = m_d.data;
    assign sub_last  = (beat_cnt_q == sub_mem_q[sub_rd_q]);
    assign s_d.last  = sub_last;
    assign d_hs      = s_d.valid && s_d.ready;
    assign orig_end  = (orig_cnt_q == orig_mem_q[orig_rd_q]);
    assign err_last  = err_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        orig_len_d = orig_len_q;
        first_d    = first_q;
        case (state_q)
            ST_IDLE: begin
                if (a_hs) begin
                    cur_addr_d = m_a.addr;
                    rem_d      = {1'b0, m_a.len} + rem_t'(1);
                    orig_len_d = m_a.len;
                    first_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sa_hs) begin
                    cur_addr_d = cur_addr_q + (ADDR_T'(chunk) << BEAT_SHIFT);
                    rem_d      = rem_q - chunk;
                    first_d    = 1'b0;
                    if (rem_q == chunk) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The original length is queued with the first sub-burst so both FIFOs stay within CMD_DEPTH.
    always_comb begin
        sub_mem_d  = sub_mem_q;
        orig_mem_d = orig_mem_q;
        sub_wr_d   = sub_wr_q;
        sub_rd_d   = sub_rd_q;
        orig_wr_d  = orig_wr_q;
        orig_rd_d  = orig_rd_q;
        cnt_d      = cnt_q;
        if (sa_hs) begin
            sub_mem_d[sub_wr_q] = chunk_len;
            sub_wr_d            = ptr_inc(sub_wr_q);
        end
        if (sa_hs && first_q) begin
            orig_mem_d[orig_wr_q] = orig_len_q;
            orig_wr_d             = ptr_inc(orig_wr_q);
        end
        if (d_hs && sub_last) begin
            sub_rd_d = ptr_inc(sub_rd_q);
        end
        if (d_hs && orig_end) begin
            orig_rd_d = ptr_inc(orig_rd_q);
        end
        case ({sa_hs, d_hs && sub_last})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        orig_cnt_d = orig_cnt_q;
        err_d      = err_q;
        if (d_hs) begin
            beat_cnt_d = sub_last ? '0 : beat_cnt_q + LEN_T'(1);
            orig_cnt_d = orig_end ? '0 : orig_cnt_q + LEN_T'(1);
            if (m_d.last != orig_end) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b0;
            sub_wr_q   <= '0;
            sub_rd_q   <= '0;
            orig_wr_q  <= '0;
            orig_rd_q  <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            orig_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            sub_wr_q   <= sub_wr_d;
            sub_rd_q   <= sub_rd_d;
            orig_wr_q  <= orig_wr_d;
            orig_rd_q  <= orig_rd_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            orig_cnt_q <= orig_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_addr_q <= cur_addr_d;
        rem_q      <= rem_d;
        orig_len_q <= orig_len_d;
        sub_mem_q  <= sub_mem_d;
        orig_mem_q <= orig_mem_d;
    end

endmodule
